instr_encoder_loader: RTL and testbench
=======================================

INSTR_ENCODER_LOADER -- requirements
Module: instr_encoder_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/data word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, instruction-memory word-address width; MEM_SIZE = 2**ADDR_WIDTH.
REQ-003 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  reset, synchronous, active-high
 start  in  1  begin load session at base_addr
 base_addr  in  ADDR_WIDTH  first word address written
 in_valid  in  1  field beat valid
 in_ready  out  1  beat accepted when in_valid & in_ready
 in_last  in  1  final beat of session
 in_op  in  7  opcode
 in_rd / in_rs1 / in_rs2  in  5 each  register fields
 in_funct3  in  3;  in_funct7  in  7
 in_imm  in  XLEN  signed immediate; byte offset for B/J
 mem_we  out  1  instruction-memory write strobe
 mem_addr  out  ADDR_WIDTH  word address
 mem_wdata  out  XLEN  encoded instruction
 busy  out  1;  done  out  1 (one-cycle pulse);  err  out  1 (sticky until start)
 count  out  ADDR_WIDTH+1  words written this session

Function
REQ-004 SHALL implement FSM IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
REQ-005 IDLE: start=1 SHALL load address pointer with base_addr, clear count and err, enter LOAD; start outside IDLE SHALL be ignored.
REQ-006 LOAD: in_ready SHALL be 1; accepted beat SHALL be encoded and registered; mem_we/mem_addr/mem_wdata SHALL appear exactly 1 cycle after acceptance (one-cycle latency, throughput 1 beat/cycle).
REQ-007 Encoding SHALL be RV32I standard: R (0110011, 0111011): funct7|rs2|rs1|f3|rd|op; I (0000011, 0010011): imm[11:0]|rs1|f3|rd|op; S (0100011): imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B (1100011): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
REQ-008 For op 0010011 with funct3 001 or 101, bits [31:25] SHALL be in_funct7 and [24:20] SHALL be in_imm[4:0].
REQ-009 Unused fields for a format SHALL be ignored; B/J in_imm[0] SHALL be ignored.
REQ-010 Unlisted opcode: beat SHALL be consumed, no write, count unchanged, err set.
REQ-011 Each write SHALL increment count and pointer; pointer SHALL wrap modulo MEM_SIZE.
REQ-012 Accepting in_last SHALL enter DRAIN (in_ready=0); DRAIN SHALL complete the pending write then enter DONE.
REQ-013 Full: if count reaches MEM_SIZE after a write without in_last, SHALL set err, drop in_ready, enter DONE.
REQ-014 DONE SHALL assert done for exactly one cycle and return to IDLE; busy SHALL be 1 in LOAD and DRAIN only.
REQ-015 count and err SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-016 rst=1 at clock edge SHALL force IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, count=0.
REQ-017 Reset mid-session SHALL discard the pending encoded word; no write in the cycle after reset.

Configuration
REQ-018 Macro IMM_RANGE_CHECK_EN: when defined, an immediate not representable in its format (I/S outside [-2048,2047], B outside [-4096,4094] or odd, J outside [-1048576,1048574] or odd, shift amount > 31) SHALL be treated as REQ-010 (consumed, not written, err set).
REQ-019 Without IMM_RANGE_CHECK_EN, immediates SHALL be truncated to the format's bits silently and written.

Verification
REQ-020 start, base_addr=0; beat op=0010011 rd=1 rs1=0 f3=000 imm=5, last -> mem_addr=0, mem_wdata=0x00500093, done pulse, count=1.
REQ-021 Beats add x3,x1,x2 (funct7=0) then sub (funct7=0x20), back-to-back -> 0x002081B3 then 0x402081B3 on consecutive cycles, addresses base, base+1.
REQ-022 sw rs2=2 rs1=1 imm=8 -> 0x0020A423; beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; jal rd=1 imm=16 -> 0x010000EF.
REQ-023 base_addr=510, three beats -> writes at 510, 511, 0; 512 beats without last from 0 -> err=1, in_ready=0 after count=512.
REQ-024 Beat op=0x7F -> no mem_we, err=1, count unchanged; with IMM_RANGE_CHECK_EN, addi imm=4096 -> no write, err=1; without, written as 0x00000093 (rd=1).
REQ-025 rst asserted the cycle after a beat is accepted -> mem_we stays 0, all outputs at reset values next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// Streams RV32I instruction fields, encodes each beat and writes it to an instruction memory.
// Optional macro IMM_RANGE_CHECK_EN rejects immediates that do not fit their format.
module instr_encoder_loader #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [6:0]             in_op,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [2:0]             in_funct3,
  input  logic [6:0]             in_funct7,
  input  logic signed [XLEN-1:0] in_imm,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_WIDTH:0]    count
);

  localparam int MEM_SIZE = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_SLOT = (ADDR_WIDTH+1)'(MEM_SIZE - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [31:0]           enc_p0;
  logic                  wr_ok_p0;

  function automatic logic op_known(input logic [6:0] op);
    case (op)
      OPC_OP, OPC_OP32, OPC_LOAD, OPC_OPIMM,
      OPC_STORE, OPC_BRANCH, OPC_JAL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [6:0] op, input logic [2:0] f3);
    return (op == OPC_OPIMM) && (f3 == 3'b001 || f3 == 3'b101);
  endfunction

  function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [20:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      OPC_OP, OPC_OP32: w = {f7, rs2, rs1, f3, rd, op};
      OPC_LOAD:         w = {imm[11:0], rs1, f3, rd, op};
      OPC_OPIMM:        w = is_shift(op, f3) ? {f7, imm[4:0], rs1, f3, rd, op}
                                             : {imm[11:0], rs1, f3, rd, op};
      OPC_STORE:        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OPC_BRANCH:       w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      OPC_JAL:          w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:          w = '0;
    endcase
    return w;
  endfunction

`ifdef IMM_RANGE_CHECK_EN
  function automatic logic imm_ok(input logic [6:0] op, input logic [2:0] f3,
                                  input logic signed [XLEN-1:0] imm);
    case (op)
      OPC_OPIMM:  return is_shift(op, f3) ? (imm >= 0 && imm <= 31)
                                          : (imm >= -2048 && imm <= 2047);
      OPC_LOAD,
      OPC_STORE:  return imm >= -2048 && imm <= 2047;
      OPC_BRANCH: return imm >= -4096 && imm <= 4094 && !imm[0];
      OPC_JAL:    return imm >= -1048576 && imm <= 1048574 && !imm[0];
      default:    return 1'b1;
    endcase
  endfunction

  assign wr_ok_p0 = op_known(in_op) && imm_ok(in_op, in_funct3, in_imm);
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[XLEN-1:21];
  assign wr_ok_p0      = op_known(in_op);
`endif

  // p0: combinational encode of the beat currently on the inputs
  assign enc_p0 = encode(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm[20:0]);

  // p1: registered memory write and session control
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr      <= base_addr;
            count    <= '0;
            err      <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (wr_ok_p0) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= XLEN'(enc_p0);
              ptr       <= ptr + 1'b1;
              count     <= count + 1'b1;
            end else begin
              err <= 1'b1;
            end
            if (in_last) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else if (wr_ok_p0 && count == LAST_SLOT) begin
              // memory is now full: close the session directly
              err      <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: table of known encodings, corner sequences, random beats vs model.
module tb_instr_encoder_loader;

  localparam int XLEN = 32;
  localparam int AW   = 9;
  localparam int MEM  = 512;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, in_last;
  logic [AW-1:0]   base_addr;
  logic [6:0]      in_op, in_funct7;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [2:0]      in_funct3;
  logic signed [XLEN-1:0] in_imm;
  logic            in_ready, mem_we, busy, done, err;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [AW:0]     count;

  instr_encoder_loader #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        we;
    logic [31:0] word;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int exp_ptr, exp_count;
  bit exp_err;
  vec_t tbl[14];
  logic [6:0] valid_ops[7] = '{7'b0110011, 7'b0111011, 7'b0000011, 7'b0010011,
                               7'b0100011, 7'b1100011, 7'b1101111};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int fld(input int v, input int hi, input int lo);
    return (v >>> lo) & ((1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder: places each field at its bit position by shifting integers.
  function automatic bit model_enc(input vec_t v, output logic [31:0] w);
    int op, rd, rs1, rs2, f3, f7, imm, base;
    op = int'(v.op); rd = int'(v.rd); rs1 = int'(v.rs1); rs2 = int'(v.rs2);
    f3 = int'(v.f3); f7 = int'(v.f7); imm = int'(v.imm);
    base = op + (f3 << 12) + (rs1 << 15);
    w = '0;
    if (op == 'h33 || op == 'h3B)
      w = 32'(base + (rd << 7) + (rs2 << 20) + (f7 << 25));
    else if (op == 'h13 && (f3 == 1 || f3 == 5))
      w = 32'(base + (rd << 7) + (fld(imm, 4, 0) << 20) + (f7 << 25));
    else if (op == 'h03 || op == 'h13)
      w = 32'(base + (rd << 7) + (fld(imm, 11, 0) << 20));
    else if (op == 'h23)
      w = 32'(base + (fld(imm, 4, 0) << 7) + (rs2 << 20) + (fld(imm, 11, 5) << 25));
    else if (op == 'h63)
      w = 32'(base + (fld(imm, 11, 11) << 7) + (fld(imm, 4, 1) << 8) + (rs2 << 20)
              + (fld(imm, 10, 5) << 25) + (fld(imm, 12, 12) << 31));
    else if (op == 'h6F)
      w = 32'(op + (rd << 7) + (fld(imm, 19, 12) << 12) + (fld(imm, 11, 11) << 20)
              + (fld(imm, 10, 1) << 21) + (fld(imm, 20, 20) << 31));
    else
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input int imm, input logic we, input logic [31:0] word);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
    v.imm = imm; v.we = we; v.word = word;
    return v;
  endfunction

  function automatic vec_t rand_vec(input bit allow_bad);
    vec_t v;
    logic [31:0] w;
    v.op  = valid_ops[$urandom_range(6)];
    if (allow_bad && $urandom_range(9) == 0) v.op = ($urandom_range(1) == 0) ? 7'h7F : 7'h37;
    v.rd  = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
    v.f3  = 3'($urandom); v.f7  = 7'($urandom); v.imm = $urandom;
    v.we  = model_enc(v, w);
    v.word = w;
    return v;
  endfunction

  task automatic beat(input vec_t v, input bit valid, input bit last, input string tag);
    in_op = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    in_valid = valid; in_last = last;
    if (valid) chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (valid && v.we) begin
      chk({tag, "_mem_we"}, mem_we, 1);
      chk({tag, "_mem_addr"}, mem_addr, exp_ptr);
      chk({tag, "_mem_wdata"}, mem_wdata, v.word);
      exp_ptr = (exp_ptr + 1) % MEM;
      exp_count++;
      if (exp_count == MEM && !last) exp_err = 1'b1;
    end else begin
      chk({tag, "_mem_we_off"}, mem_we, 0);
      if (valid) exp_err = 1'b1;
    end
    chk({tag, "_count"}, count, exp_count);
    chk({tag, "_err"}, err, exp_err);
  endtask

  task automatic begin_session(input int base);
    start = 1'b1; base_addr = AW'(base);
    @(posedge clk); #1;
    start = 1'b0;
    exp_ptr = base; exp_count = 0; exp_err = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", in_ready, 1);
    chk("start_count", count, 0);
    chk("start_err", err, 0);
  endtask

  task automatic end_after_last(input string tag);
    chk({tag, "_drain_ready"}, in_ready, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    chk({tag, "_drain_done"}, done, 0);
    @(posedge clk); #1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_busy"}, busy, 0);
    chk({tag, "_done_we"}, mem_we, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse_end"}, done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold_count"}, count, exp_count);
    chk({tag, "_hold_err"}, err, exp_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_count"}, count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = mk(7'h13, 1, 0, 0, 3'b000, 0,     5,    1, 32'h00500093);
    tbl[1]  = mk(7'h33, 3, 1, 2, 3'b000, 0,     0,    1, 32'h002081B3);
    tbl[2]  = mk(7'h33, 3, 1, 2, 3'b000, 7'h20, 0,    1, 32'h402081B3);
    tbl[3]  = mk(7'h23, 31, 1, 2, 3'b010, 7'h55, 8,   1, 32'h0020A423);
    tbl[4]  = mk(7'h63, 7, 1, 2, 3'b000, 7'h11, -4,   1, 32'hFE208EE3);
    tbl[5]  = mk(7'h6F, 1, 5, 9, 3'b011, 7'h7F, 16,   1, 32'h010000EF);
    tbl[6]  = mk(7'h7F, 1, 1, 1, 3'b000, 0,     0,    0, 32'h0);
    tbl[7]  = mk(7'h13, 1, 0, 0, 3'b000, 0,     4096, 1, 32'h00000093);
    tbl[8]  = mk(7'h13, 5, 5, 0, 3'b001, 0,     3,    1, 32'h00329293);
    tbl[9]  = mk(7'h13, 2, 2, 0, 3'b101, 7'h20, 4,    1, 32'h40415113);
    tbl[10] = mk(7'h03, 3, 2, 0, 3'b010, 0,     -1,   1, 32'hFFF12183);
    tbl[11] = mk(7'h6F, 1, 0, 0, 3'b000, 0,     17,   1, 32'h010000EF);
    tbl[12] = mk(7'h63, 0, 1, 2, 3'b000, 0,     -3,   1, 32'hFE208EE3);
    tbl[13] = mk(7'h3B, 3, 1, 2, 3'b000, 0,     0,    1, 32'h002081BB);

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", in_ready, 0);

    // single addi session at base 0
    begin_session(0);
    beat(tbl[0], 1'b1, 1'b1, "addi_single");
    end_after_last("addi_single");
    chk("addi_single_count1", count, 1);

    // whole table back-to-back in one session
    begin_session(20);
    for (int i = 0; i < 14; i++)
      beat(tbl[i], 1'b1, i == 13, $sformatf("tbl%0d", i));
    end_after_last("tbl");

    // wrap at the top of memory; a start while loading must be ignored
    begin_session(510);
    beat(rand_vec(0), 1'b1, 1'b0, "wrap0");
    start = 1'b1; base_addr = 7;
    beat(rand_vec(0), 1'b1, 1'b0, "wrap1");
    start = 1'b0;
    beat(rand_vec(0), 1'b1, 1'b1, "wrap2");
    end_after_last("wrap");

    // fill memory completely without in_last
    begin_session(0);
    for (int i = 0; i < MEM; i++) begin
      v = rand_vec(0);
      v.we = model_enc(v, v.word);
      beat(v, 1'b1, 1'b0, "full");
    end
    chk("full_ready_drop", in_ready, 0);
    chk("full_done", done, 1);
    chk("full_err", err, 1);
    chk("full_busy", busy, 0);
    chk("full_count", count, MEM);
    @(posedge clk); #1;
    chk("full_done_end", done, 0);
    chk("full_count_hold", count, MEM);

    // randomized session with idle gaps and unknown opcodes
    begin_session($urandom_range(MEM - 1));
    for (int i = 0; i < 60; i++)
      beat(rand_vec(1), $urandom_range(3) != 0, i == 59, "rand");
    chk("rand_count_model", count, exp_count);
    end_after_last("rand");

    // reset the cycle after an accepted beat
    begin_session(3);
    beat(tbl[0], 1'b1, 1'b0, "rst_mid");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("rst_mid_after");
    @(posedge clk); #1;
    chk("rst_mid_no_write", mem_we, 0);
    chk("rst_mid_idle_ready", in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
